axi_ram_slave: RTL
==================

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (8, 16, 32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte address width; memory depth is 2^ADDR_WIDTH bytes.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, write strobe width.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named as follows:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset
s_axi_awaddr  input  ADDR_WIDTH  write burst start byte address
s_axi_awlen  input  8  beats minus one
s_axi_awvalid  input  1  AW valid
s_axi_awready  output  1  AW ready
s_axi_wdata  input  DATA_WIDTH  write data
s_axi_wstrb  input  STRB_WIDTH  byte enables
s_axi_wlast  input  1  last write beat (ignored)
s_axi_wvalid  input  1  W valid
s_axi_wready  output  1  W ready
s_axi_bresp  output  2  write response
s_axi_bvalid  output  1  B valid
s_axi_bready  input  1  B ready
s_axi_araddr  input  ADDR_WIDTH  read burst start byte address
s_axi_arlen  input  8  beats minus one
s_axi_arvalid  input  1  AR valid
s_axi_arready  output  1  AR ready
s_axi_rdata  output  DATA_WIDTH  read data
s_axi_rresp  output  2  read response
s_axi_rlast  output  1  last read beat
s_axi_rvalid  output  1  R valid
s_axi_rready  input  1  R ready

Function
REQ-005 SHALL support only INCR bursts of full bus width; size, burst, lock, cache, prot, qos, region and user signals SHALL NOT exist.
REQ-006 Word index SHALL be addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]; low bits ignored (aligned); index SHALL increment by 1 per beat, wrapping modulo 2^(ADDR_WIDTH-log2(STRB_WIDTH)).
REQ-007 Write FSM states SHALL be W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-008 W_IDLE->W_DATA on AW handshake, latching address and awlen; wready SHALL be high the following cycle.
REQ-009 Each W handshake SHALL write the bytes with wstrb set at the current index, same edge; strb=0 beats SHALL consume a beat without writing.
REQ-010 W_DATA->W_RESP after awlen+1 W handshakes regardless of wlast; bvalid SHALL rise the cycle after the final beat.
REQ-011 W_RESP->W_IDLE on B handshake; bresp and rresp SHALL always be 2'b00 (OKAY).
REQ-012 Read FSM states SHALL be R_IDLE, R_BURST; arready=1 only in R_IDLE; R_IDLE->R_BURST on AR handshake, latching address and arlen.
REQ-013 First rvalid SHALL assert exactly 1 cycle after AR handshake; with rready held high, one beat per cycle, no bubbles.
REQ-014 rdata, rlast, rvalid SHALL be registered and held stable while rvalid=1 and rready=0.
REQ-015 rlast SHALL be 1 on beat arlen only; R_BURST->R_IDLE on the R handshake of that beat; arready high next cycle.
REQ-016 Read and write paths SHALL operate concurrently and independently; a read and write to the same word on the same edge SHALL return the old data.
REQ-017 Memory contents SHALL NOT be initialized or cleared by reset.

Reset
REQ-018 While rst=1: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp = 2'b00; rdata = 0; both FSMs to IDLE.
REQ-019 Reset mid-burst SHALL abort the burst without response; awready and arready SHALL be 1 the first cycle after rst deasserts.

Verification
REQ-020 AW addr 0x0010 len 3, 4 beats 0x11111111..0x44444444 strb 0xF, bready=1 -> one bvalid, bresp=00; read addr 0x0010 len 3 returns same 4 words, rlast on 4th.
REQ-021 Write 0xAABBCCDD to 0x0020 then 0x000000EE strb 0x1 -> read 0x0020 returns 0xAABBCCEE.
REQ-022 Read len 7 with rready toggling 1,0,1,0 -> 8 beats in order, data stable during stalls, rlast only on 8th.
REQ-023 Write len 1 at 0xFFFC (ADDR_WIDTH=16) -> second beat lands at 0x0000; read 0x0000 confirms wrap.
REQ-024 Assert rst after 2 of 4 write beats -> no bvalid; awready=1 the cycle after release; new write completes normally.

Source files
------------

// File: rtl/axi_ram_slave_if.sv
// AXI4 write/read channel bundle for axi_ram_slave: INCR full-width bursts only,
// so no size/burst/lock/cache/prot/qos/region/user fields are carried.
interface axi_ram_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by a byte-enabled word RAM; independent write and read
// burst engines share only the memory array (read-first on same-word collision).
module axi_ram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input logic            clk,
  input logic            rst,
  axi_ram_slave_if.slave s_axi
);
  localparam int LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W = ADDR_WIDTH - LSB;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_BURST}        r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t              w_state_q, w_state_d;
  logic [IDX_W-1:0]      w_idx_q, w_idx_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  mem_we;

  r_state_t              r_state_q, r_state_d;
  logic [IDX_W-1:0]      r_idx_q, r_idx_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rd_en;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  unused_bits;

  // Byte-offset address bits and wlast carry no information for this slave.
  assign unused_bits = ^{s_axi.wlast, s_axi.awaddr, s_axi.araddr};

  assign s_axi.awready = (w_state_q == W_IDLE) && !rst;
  assign s_axi.wready  = (w_state_q == W_DATA) && !rst;
  assign s_axi.bvalid  = (w_state_q == W_RESP) && !rst;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = (r_state_q == R_IDLE) && !rst;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid  && s_axi.wready;
  assign b_hs  = s_axi.bvalid  && s_axi.bready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign r_hs  = s_axi.rvalid  && s_axi.rready;

  // Write engine: w_cnt_q counts beats still owed after the current one.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_state_d = W_DATA;
          w_idx_d   = s_axi.awaddr[ADDR_WIDTH-1:LSB];
          w_cnt_d   = s_axi.awlen;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          mem_we  = 1'b1;
          w_idx_d = w_idx_q + 1'b1;
          if (w_cnt_q == 8'd0) begin
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q - 8'd1;
          end
        end
      end
      W_RESP: begin
        if (b_hs) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
    end
  end

  // Contents survive reset; a beat landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi.wstrb[i]) begin
          mem[w_idx_q][i*8 +: 8] <= s_axi.wdata[i*8 +: 8];
        end
      end
    end
  end

  // Read engine prefetches the next word on each accepted beat so rvalid never bubbles.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rd_en     = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_BURST;
          r_idx_d   = s_axi.araddr[ADDR_WIDTH-1:LSB];
          r_cnt_d   = s_axi.arlen;
          rvalid_d  = 1'b1;
          rlast_d   = (s_axi.arlen == 8'd0);
          rd_en     = 1'b1;
        end
      end
      R_BURST: begin
        if (r_hs) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            r_idx_d = r_idx_q + 1'b1;
            r_cnt_d = r_cnt_q - 8'd1;
            rlast_d = (r_cnt_q == 8'd1);
            rd_en   = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem[r_idx_d];
    end
  end
endmodule
